// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding and registers MEM/WB outputs.
//
//   state | meaning
//   IDLE  | no access outstanding; non-memory ops pass through in one cycle
//   WAIT  | request issued, waiting for dmem_ack or timeout
module mem_access_stage #(
  parameter int DSIZE    = 16,
  parameter int ASIZE    = 4,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] alu_result_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic             memWrite_in,
  input  logic             memRead_in,
  input  logic             memToReg_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             WriteEn_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic [DSIZE-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             stall,
  output logic [DSIZE-1:0] wb_data_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             WriteEn_out,
  output logic             mem_err
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state, nextState;
  logic [CW-1:0]   waitCnt;
  logic            memToRegQ;
  logic [ASIZE-1:0] waddrQ;
  logic            wenQ;
  logic            memOp;
  logic            timeout;

  assign memOp   = memRead_in | memWrite_in;
  assign timeout = (state == WAIT) && !dmem_ack && (waitCnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (memOp) nextState = WAIT;
      WAIT: if (dmem_ack || timeout) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Stall drops in the ack/timeout cycle so EX/MEM advances on that edge.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE: stall = memOp;
      WAIT: stall = !dmem_ack && !timeout;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      memToRegQ   <= 1'b0;
      waddrQ      <= '0;
      wenQ        <= 1'b0;
      waitCnt     <= '0;
      wb_data_out <= '0;
      waddr_out   <= '0;
      WriteEn_out <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memOp) begin
            dmem_addr   <= alu_result_in;
            dmem_wdata  <= rdata2_in;
            dmem_we     <= memWrite_in;
            memToRegQ   <= memToReg_in;
            waddrQ      <= waddr_in;
            wenQ        <= WriteEn_in;
            dmem_req    <= 1'b1;
            waitCnt     <= '0;
            WriteEn_out <= 1'b0;
          end else begin
            wb_data_out <= alu_result_in;
            waddr_out   <= waddr_in;
            WriteEn_out <= WriteEn_in;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            wb_data_out <= (memToRegQ && !dmem_we) ? dmem_rdata : dmem_addr;
            waddr_out   <= waddrQ;
            WriteEn_out <= wenQ;
          end else if (timeout) begin
            dmem_req    <= 1'b0;
            mem_err     <= 1'b1;
            WriteEn_out <= 1'b0;
          end else begin
            waitCnt     <= waitCnt + CW'(1);
            WriteEn_out <= 1'b0;
          end
        end
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, load, store, timeout and
// reset scenarios with hand-computed expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aluRes, rdata2, dmemRdata;
  logic        memWrite, memRead, memToReg, writeEn, dmemAck;
  logic [3:0]  waddr;
  logic        dmemReq, dmemWe, stall, writeEnOut, memErr;
  logic [15:0] dmemAddr, dmemWdata, wbData;
  logic [3:0]  waddrOut;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DSIZE(16), .ASIZE(4), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst),
    .alu_result_in(aluRes), .rdata2_in(rdata2),
    .memWrite_in(memWrite), .memRead_in(memRead), .memToReg_in(memToReg),
    .waddr_in(waddr), .WriteEn_in(writeEn),
    .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr),
    .dmem_wdata(dmemWdata), .dmem_rdata(dmemRdata), .dmem_ack(dmemAck),
    .stall(stall), .wb_data_out(wbData), .waddr_out(waddrOut),
    .WriteEn_out(writeEnOut), .mem_err(memErr)
  );

  task automatic clrIn();
    aluRes = '0; rdata2 = '0; memWrite = 0; memRead = 0; memToReg = 0;
    waddr = '0; writeEn = 0; dmemAck = 0; dmemRdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clrIn(); rst = 0;
    repeat (2) step();
    rst = 1; step();
    aluRes = 16'hFFFF; waddr = 4'hF; writeEn = 1;
    step();
    tests++; if (wbData !== 16'hFFFF) begin fails++; $display("FAIL pre_reset_wb got %h exp ffff", wbData); end
    clrIn();
    #2 rst = 0; #1;
    tests++; if (wbData !== 16'h0) begin fails++; $display("FAIL rst_wb got %h exp 0", wbData); end
    tests++; if (waddrOut !== 4'h0) begin fails++; $display("FAIL rst_waddr got %h exp 0", waddrOut); end
    tests++; if (writeEnOut !== 1'b0) begin fails++; $display("FAIL rst_we got %b exp 0", writeEnOut); end
    tests++; if ({dmemReq, dmemWe, stall, memErr} !== 4'b0) begin fails++; $display("FAIL rst_ctrl got %b exp 0000", {dmemReq, dmemWe, stall, memErr}); end
    tests++; if ({dmemAddr, dmemWdata} !== 32'h0) begin fails++; $display("FAIL rst_dmem got %h exp 0", {dmemAddr, dmemWdata}); end
    #2 rst = 1;
    step();
  endtask

  task automatic test_alu();
    clrIn(); aluRes = 16'h1234; waddr = 4'd3; writeEn = 1;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_stall got %b exp 0", stall); end
    step();
    tests++; if (wbData !== 16'h1234) begin fails++; $display("FAIL alu_wb got %h exp 1234", wbData); end
    tests++; if (waddrOut !== 4'd3) begin fails++; $display("FAIL alu_waddr got %h exp 3", waddrOut); end
    tests++; if (writeEnOut !== 1'b1) begin fails++; $display("FAIL alu_we got %b exp 1", writeEnOut); end
    clrIn();
  endtask

  task automatic test_load();
    clrIn(); aluRes = 16'h0040; memRead = 1; memToReg = 1; waddr = 4'd5; writeEn = 1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL load_idle_stall got %b exp 1", stall); end
    step();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin dmemAck = 1; dmemRdata = 16'hBEEF; end
      #1;
      tests++; if (dmemReq !== 1'b1 || dmemAddr !== 16'h0040 || dmemWe !== 1'b0) begin
        fails++; $display("FAIL load_req_c%0d got req=%b addr=%h we=%b exp 1/0040/0", k, dmemReq, dmemAddr, dmemWe); end
      tests++; if (stall !== (k < 3)) begin fails++; $display("FAIL load_stall_c%0d got %b exp %b", k, stall, (k < 3)); end
      if (k == 1) begin
        tests++; if (writeEnOut !== 1'b0) begin fails++; $display("FAIL load_bubble got %b exp 0", writeEnOut); end
      end
      step();
      dmemAck = 0;
    end
    clrIn();
    tests++; if (dmemReq !== 1'b0) begin fails++; $display("FAIL load_req_drop got %b exp 0", dmemReq); end
    tests++; if (wbData !== 16'hBEEF) begin fails++; $display("FAIL load_wb got %h exp beef", wbData); end
    tests++; if (waddrOut !== 4'd5 || writeEnOut !== 1'b1) begin fails++; $display("FAIL load_dest got %h/%b exp 5/1", waddrOut, writeEnOut); end
  endtask

  task automatic test_back_to_back();
    clrIn(); aluRes = 16'h0010; rdata2 = 16'hA5A5; memRead = 1; memWrite = 1;
    memToReg = 1; waddr = 4'd7; writeEn = 1;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL store_idle_stall got %b exp 1", stall); end
    step();
    dmemAck = 1; dmemRdata = 16'hDEAD;
    #1;
    tests++; if (dmemReq !== 1'b1 || dmemWe !== 1'b1 || dmemWdata !== 16'hA5A5) begin
      fails++; $display("FAIL store_port got req=%b we=%b wdata=%h exp 1/1/a5a5", dmemReq, dmemWe, dmemWdata); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL store_ack_stall got %b exp 0", stall); end
    step();
    clrIn(); aluRes = 16'h5555; waddr = 4'd2; writeEn = 1;
    tests++; if (wbData !== 16'h0010) begin fails++; $display("FAIL store_wb got %h exp 0010", wbData); end
    tests++; if (waddrOut !== 4'd7 || writeEnOut !== 1'b1) begin fails++; $display("FAIL store_dest got %h/%b exp 7/1", waddrOut, writeEnOut); end
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall got %b exp 0", stall); end
    step();
    tests++; if (wbData !== 16'h5555 || waddrOut !== 4'd2 || writeEnOut !== 1'b1) begin
      fails++; $display("FAIL b2b_alu got %h/%h/%b exp 5555/2/1", wbData, waddrOut, writeEnOut); end
    clrIn();
  endtask

  task automatic test_timeout();
    int stallCnt;
    stallCnt = 0;
    clrIn(); aluRes = 16'h0080; memRead = 1; memToReg = 1; waddr = 4'd9; writeEn = 1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) break;
      stallCnt++;
      step();
    end
    tests++; if (stallCnt !== 16) begin fails++; $display("FAIL to_stall_cycles got %0d exp 16", stallCnt); end
    tests++; if (dmemReq !== 1'b1) begin fails++; $display("FAIL to_req_last got %b exp 1", dmemReq); end
    clrIn();
    step();
    tests++; if (dmemReq !== 1'b0) begin fails++; $display("FAIL to_req_drop got %b exp 0", dmemReq); end
    tests++; if (memErr !== 1'b1 || writeEnOut !== 1'b0) begin fails++; $display("FAIL to_err got err=%b we=%b exp 1/0", memErr, writeEnOut); end
    aluRes = 16'h0F0F; waddr = 4'd1; writeEn = 1;
    step();
    tests++; if (memErr !== 1'b1 || wbData !== 16'h0F0F || writeEnOut !== 1'b1) begin
      fails++; $display("FAIL to_sticky got err=%b wb=%h we=%b exp 1/0f0f/1", memErr, wbData, writeEnOut); end
    clrIn();
  endtask

  task automatic test_reset_mid();
    clrIn(); aluRes = 16'h0100; memRead = 1; memToReg = 1; waddr = 4'd6; writeEn = 1;
    step();
    step();
    tests++; if (dmemReq !== 1'b1) begin fails++; $display("FAIL mid_req_before got %b exp 1", dmemReq); end
    clrIn();
    #2 rst = 0; #1;
    tests++; if (dmemReq !== 1'b0 || stall !== 1'b0 || memErr !== 1'b0) begin
      fails++; $display("FAIL mid_rst got req=%b stall=%b err=%b exp 0/0/0", dmemReq, stall, memErr); end
    #2 rst = 1;
    step();
    tests++; if (writeEnOut !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL mid_after got we=%b stall=%b exp 0/0", writeEnOut, stall); end
    dmemAck = 1; dmemRdata = 16'h1111;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL late_ack_stall got %b exp 0", stall); end
    step();
    dmemAck = 0;
    tests++; if (writeEnOut !== 1'b0 || dmemReq !== 1'b0 || wbData !== 16'h0) begin
      fails++; $display("FAIL late_ack got we=%b req=%b wb=%h exp 0/0/0000", writeEnOut, dmemReq, wbData); end
  endtask

  initial begin
    clrIn(); rst = 0;
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
